// File: rtl/izh_pkg.sv
// Shared constants and types for the Izhikevich v/u state bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Q8.8 number format, resting-state constants, the {v,u} state word and the
// init-sweep FSM states. Optional build macro: IZH_STATE_PARITY_EN adds two
// even-parity bits to every stored word.
package izh_pkg;

    localparam int IZH_NUM_WIDTH = 17;
    localparam int IZH_FRAC_BITS = 8;

    // Resting state: v = -65.0, u = b*v = 0.2 * -65 = -13.0 (Q8.8).
    localparam int IZH_V_INIT = -(65 <<< IZH_FRAC_BITS);
    localparam int IZH_U_INIT = -(13 <<< IZH_FRAC_BITS);

`ifdef IZH_STATE_PARITY_EN
    localparam int IZH_PAR_BITS = 2;
`else
    localparam int IZH_PAR_BITS = 0;
`endif

    typedef struct packed {
        logic [IZH_NUM_WIDTH-1:0] v;
        logic [IZH_NUM_WIDTH-1:0] u;
    } izh_state_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } izh_fsm_e;

endpackage

// File: rtl/izh_state_mem.sv
// Simple dual-port state array: one write port, one registered read port.
// Latency: read data valid one cycle after re_i; write lands at the edge.
// Backpressure: none; both ports accept every cycle.
//
// Ports: clk; we_i/waddr_i/wdata_i write port; re_i/raddr_i read port;
// rdata_o registered read data (holds when re_i is low).
// Storage and read register are deliberately not reset. The word width
// includes parity bits when IZH_STATE_PARITY_EN is defined.
module izh_state_mem
    import izh_pkg::*;
#(
    parameter  int NUM_WIDTH = IZH_NUM_WIDTH,
    parameter  int DEPTH     = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int WORD_W    = 2*NUM_WIDTH + IZH_PAR_BITS
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Read-before-write on a same-address collision; the top-level bypass
    // supplies write-first behaviour.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/izh_state_bank.sv
// v/u state store for the Izhikevich update pipeline, one entry per neuron tag.
// Latency: read 1 cycle (rd_en at edge t -> rd_valid/v_out/u_out after t).
// Backpressure: none; rd_en/wr_en ignored while ready=0 (init sweep).
//
// Ports: clk, asyn_reset (async, active-high), clr (sync soft clear),
// ready; read port rd_en/rd_tag -> rd_valid/v_out/u_out; write port
// wr_en/wr_tag/v_new/u_new. With IZH_STATE_PARITY_EN defined an extra
// par_err output flags a stored-parity mismatch on a read.
module izh_state_bank
    import izh_pkg::*;
#(
    parameter  int                   NUM_WIDTH   = IZH_NUM_WIDTH,
    parameter  int                   NUM_NEURONS = 4,
    parameter  logic [NUM_WIDTH-1:0] V_INIT      = NUM_WIDTH'(IZH_V_INIT),
    parameter  logic [NUM_WIDTH-1:0] U_INIT      = NUM_WIDTH'(IZH_U_INIT),
    localparam int                   TAG_BITS    = $clog2(NUM_NEURONS)
) (
    input  logic                 clk,
    input  logic                 asyn_reset,
    input  logic                 clr,
    output logic                 ready,
    input  logic                 rd_en,
    input  logic [TAG_BITS-1:0]  rd_tag,
    output logic                 rd_valid,
    output logic [NUM_WIDTH-1:0] v_out,
    output logic [NUM_WIDTH-1:0] u_out,
    input  logic                 wr_en,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [NUM_WIDTH-1:0] v_new,
    input  logic [NUM_WIDTH-1:0] u_new
`ifdef IZH_STATE_PARITY_EN
    ,
    output logic                 par_err
`endif
);

    localparam int WORD_W = 2*NUM_WIDTH + IZH_PAR_BITS;
    localparam logic [TAG_BITS-1:0] LAST_TAG = TAG_BITS'(NUM_NEURONS - 1);

    function automatic logic [WORD_W-1:0] pack_word(input logic [NUM_WIDTH-1:0] v,
                                                    input logic [NUM_WIDTH-1:0] u);
`ifdef IZH_STATE_PARITY_EN
        return {^v, ^u, v, u};
`else
        return {v, u};
`endif
    endfunction

    izh_fsm_e               state_q;
    logic [TAG_BITS-1:0]    cnt_q;
    logic                   rd_valid_q;
    logic                   have_q;     // at least one read since reset
    logic                   byp_q;      // last read was served by the bypass
    logic [NUM_WIDTH-1:0]   byp_v_q;
    logic [NUM_WIDTH-1:0]   byp_u_q;

    logic                   mem_we;
    logic [TAG_BITS-1:0]    mem_waddr;
    logic [WORD_W-1:0]      mem_wdata;
    logic [WORD_W-1:0]      mem_rdata;
    logic                   rd_go;
    logic                   wr_go;
    logic                   byp_hit;
    logic [NUM_WIDTH-1:0]   mem_v;
    logic [NUM_WIDTH-1:0]   mem_u;

    // clr wins over both ports; ready is only high in RUN.
    assign ready   = (state_q == RUN);
    assign rd_go   = ready && rd_en && !clr;
    assign wr_go   = ready && wr_en && !clr;
    assign byp_hit = rd_go && wr_go && (rd_tag == wr_tag);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_tag;
        mem_wdata = pack_word(v_new, u_new);
        if (state_q == INIT) begin
            // A clr during the sweep restarts it; no entry written that cycle.
            if (!clr) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = pack_word(V_INIT, U_INIT);
            end
        end else if (wr_go) begin
            mem_we = 1'b1;
        end
    end

    izh_state_mem #(
        .NUM_WIDTH (NUM_WIDTH),
        .DEPTH     (NUM_NEURONS)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (rd_go),
        .raddr_i (rd_tag),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            have_q     <= 1'b0;
            byp_q      <= 1'b0;
            byp_v_q    <= '0;
            byp_u_q    <= '0;
        end else begin
            rd_valid_q <= rd_go;
            if (rd_go) begin
                have_q <= 1'b1;
                byp_q  <= byp_hit;
                if (byp_hit) begin
                    byp_v_q <= v_new;
                    byp_u_q <= u_new;
                end
            end
            case (state_q)
                INIT: begin
                    if (clr) begin
                        cnt_q <= '0;
                    end else if (cnt_q == LAST_TAG) begin
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (clr) begin
                        cnt_q   <= '0;
                        state_q <= INIT;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign mem_v = mem_rdata[2*NUM_WIDTH-1:NUM_WIDTH];
    assign mem_u = mem_rdata[NUM_WIDTH-1:0];

    // Outputs read 0 until the first read after reset, since the memory read
    // register itself has no reset; afterwards they hold the last read.
    assign rd_valid = rd_valid_q;
    assign v_out    = !have_q ? '0 : (byp_q ? byp_v_q : mem_v);
    assign u_out    = !have_q ? '0 : (byp_q ? byp_u_q : mem_u);

`ifdef IZH_STATE_PARITY_EN
    // Bypassed data never touched the array, so it cannot carry an error.
    assign par_err = rd_valid_q && !byp_q &&
                     ((^mem_v != mem_rdata[2*NUM_WIDTH+1]) ||
                      (^mem_u != mem_rdata[2*NUM_WIDTH]));
`endif

endmodule

// File: tb/tb_izh_state_bank.sv
// Directed testbench for izh_state_bank: reset/sweep timing, read/write table,
// bypass, clr priority and asynchronous reset in the middle of a sweep.
module tb_izh_state_bank;
    import izh_pkg::*;

    localparam int NW = 17;
    localparam logic [NW-1:0] V_I = 17'h1BF00;  // -16640
    localparam logic [NW-1:0] U_I = 17'h1F300;  // -3328

    logic          clk = 1'b0;
    logic          asyn_reset, clr, ready, rd_en, rd_valid, wr_en;
    logic [1:0]    rd_tag, wr_tag;
    logic [NW-1:0] v_out, u_out, v_new, u_new;
`ifdef IZH_STATE_PARITY_EN
    logic          par_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    izh_state_bank #(.NUM_WIDTH(NW), .NUM_NEURONS(4)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .clr        (clr),
        .ready      (ready),
        .rd_en      (rd_en),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid),
        .v_out      (v_out),
        .u_out      (u_out),
        .wr_en      (wr_en),
        .wr_tag     (wr_tag),
        .v_new      (v_new),
        .u_new      (u_new)
`ifdef IZH_STATE_PARITY_EN
        ,
        .par_err    (par_err)
`endif
    );

    typedef struct {
        logic          rd;
        logic [1:0]    rt;
        logic          wr;
        logic [1:0]    wt;
        logic [NW-1:0] wv;
        logic [NW-1:0] wu;
        logic          ev;
        izh_state_t    exp;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic rd, input logic [1:0] rt,
                                input logic wr, input logic [1:0] wt,
                                input logic [NW-1:0] wv, input logic [NW-1:0] wu,
                                input logic ev, input logic [NW-1:0] xv,
                                input logic [NW-1:0] xu);
        vec_t r;
        r.rd = rd; r.rt = rt; r.wr = wr; r.wt = wt; r.wv = wv; r.wu = wu;
        r.ev = ev; r.exp.v = xv; r.exp.u = xu;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [1:0] rt, input logic wr,
                         input logic [1:0] wt, input logic [NW-1:0] wv,
                         input logic [NW-1:0] wu);
        @(negedge clk);
        rd_en = rd; rd_tag = rt; wr_en = wr; wr_tag = wt; v_new = wv; u_new = wu;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 2'd0, '0, '0);
    endtask

    // Sweep after a reset release or clr edge: ready must stay low for
    // 'cycles' edges, rise on the last one, and held rd_en must be ignored.
    task automatic sweep_check(input string name, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step();
            chk({name, "_ready"}, 32'(ready), 32'(i == last));
            chk({name, "_no_rdvalid"}, 32'(rd_valid), 32'd0);
        end
    endtask

    task automatic read_check(input string name, input logic [1:0] tag,
                              input logic [NW-1:0] xv, input logic [NW-1:0] xu);
        drive(1'b1, tag, 1'b0, 2'd0, '0, '0);
        step();
        chk({name, "_valid"}, 32'(rd_valid), 32'd1);
        chk({name, "_v"}, 32'(v_out), 32'(xv));
        chk({name, "_u"}, 32'(u_out), 32'(xu));
    endtask

    initial begin
        asyn_reset = 1'b1; clr = 1'b0;
        rd_en = 1'b0; rd_tag = '0; wr_en = 1'b0; wr_tag = '0; v_new = '0; u_new = '0;

        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[2]  = mk(1, 2, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[3]  = mk(1, 3, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, V_I, U_I);                        // hold
        tbl[5]  = mk(0, 0, 1, 2, 17'h00100, 17'h1FF00, 0, V_I, U_I);        // write tag2
        tbl[6]  = mk(1, 2, 0, 0, 0, 0, 1, 17'h00100, 17'h1FF00);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[8]  = mk(1, 1, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[9]  = mk(1, 3, 0, 0, 0, 0, 1, V_I, U_I);
        tbl[10] = mk(1, 1, 1, 1, 17'h00A00, 17'h00123, 1, 17'h00A00, 17'h00123); // bypass
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 17'h00A00, 17'h00123);            // bypass hold
        tbl[12] = mk(1, 3, 1, 1, 17'h00B00, 17'h00456, 1, V_I, U_I);        // independent
        tbl[13] = mk(1, 1, 0, 0, 0, 0, 1, 17'h00B00, 17'h00456);

        // Reset state while asyn_reset is held.
        step(); step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_v_out", 32'(v_out), 32'd0);
        chk("rst_u_out", 32'(u_out), 32'd0);

        // Release: ready low for 4 cycles, high after the 4th edge.
        @(negedge clk);
        asyn_reset = 1'b0;
        rd_en = 1'b1;
        sweep_check("sweep0", 1, 4);

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].rd, tbl[i].rt, tbl[i].wr, tbl[i].wt, tbl[i].wv, tbl[i].wu);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_v", i), 32'(v_out), 32'(tbl[i].exp.v));
            chk($sformatf("vec%0d_u", i), 32'(u_out), 32'(tbl[i].exp.u));
`ifdef IZH_STATE_PARITY_EN
            chk($sformatf("vec%0d_par", i), 32'(par_err), 32'd0);
`endif
        end

        // clr with a write and a read in the same cycle: both dropped.
        drive(1'b1, 2'd0, 1'b1, 2'd0, 17'h00500, 17'h00777);
        clr = 1'b1;
        step();
        chk("clr_ready", 32'(ready), 32'd0);
        chk("clr_rd_dropped", 32'(rd_valid), 32'd0);
        @(negedge clk);
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        sweep_check("sweep_clr", 2, 5);
        read_check("clr_tag0", 2'd0, V_I, U_I);
        read_check("clr_tag2", 2'd2, V_I, U_I);
        read_check("clr_tag1", 2'd1, V_I, U_I);

        // Asynchronous reset right after a read completes.
        drive(1'b1, 2'd2, 1'b0, 2'd0, '0, '0);
        step();
        chk("midread_valid", 32'(rd_valid), 32'd1);
        #2 asyn_reset = 1'b1;
        #1;
        chk("midread_rst_valid", 32'(rd_valid), 32'd0);
        chk("midread_rst_v", 32'(v_out), 32'd0);
        chk("midread_rst_ready", 32'(ready), 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;
        sweep_check("sweep_rst1", 1, 4);
        read_check("post_rst1_tag3", 2'd3, V_I, U_I);

        // Asynchronous reset at sweep cycle 2 (after a clr-started sweep).
        idle();
        clr = 1'b1;
        step();
        @(negedge clk);
        clr = 1'b0; rd_en = 1'b1;
        step(); step();
        chk("sweep2_ready", 32'(ready), 32'd0);
        chk("sweep2_hold_v", 32'(v_out), 32'(V_I));
        #2 asyn_reset = 1'b1;
        #1;
        chk("sweep2_rst_v", 32'(v_out), 32'd0);
        chk("sweep2_rst_u", 32'(u_out), 32'd0);
        @(negedge clk);
        asyn_reset = 1'b0;
        sweep_check("sweep_rst2", 1, 4);
        read_check("post_rst2_tag0", 2'd0, V_I, U_I);

`ifdef IZH_STATE_PARITY_EN
        // Corrupt one stored v bit of tag3 behind the parity bit's back.
        idle();
        dut.u_mem.mem_q[3][NW] = ~dut.u_mem.mem_q[3][NW];
        drive(1'b1, 2'd3, 1'b0, 2'd0, '0, '0);
        step();
        chk("par_tag3_valid", 32'(rd_valid), 32'd1);
        chk("par_tag3_err", 32'(par_err), 32'd1);
        drive(1'b1, 2'd1, 1'b0, 2'd0, '0, '0);
        step();
        chk("par_tag1_err", 32'(par_err), 32'd0);
`endif

        idle();
        step();
        chk("final_idle_valid", 32'(rd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Hard stop in case something above never returns.
    initial begin
        #200000;
        $display("FAIL timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/izh_state_bank.md
Name: izh_state_bank

Overview:
- Parametrised v/u state store for the Izhikevich neuron update pipeline; one entry per neuron, addressed by neuron tag.
- Provides one registered read port and one write port, usable in the same cycle, so the update stage reads neuron n while writing back neuron m.
- Storage is held in array memory, not reset flops. After reset or a soft clear, an init-sweep FSM loads the Izhikevich resting state into every entry.
- Sits between the tag scheduler (read side) and the update datapath (write-back side).

Parameters:
- NUM_WIDTH, 17, width of each of v and u; signed two's complement Q8.8 (1 sign + 8 int + 8 frac).
- NUM_NEURONS, 4, number of entries; power of two, >= 2.
- TAG_BITS, $clog2(NUM_NEURONS), tag width; localparam, not overridable.
- V_INIT, -16640, reset value of v (-65.0 in Q8.8).
- U_INIT, -3328, reset value of u (b*v = 0.2 * -65 = -13.0 in Q8.8).

Ports:
- clk  in  1  single clock; all logic on posedge.
- asyn_reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous soft clear; restarts the init sweep.
- ready  out  1  high when the init sweep is complete and ports are live.
- rd_en  in  1  read request.
- rd_tag  in  TAG_BITS  read address.
- rd_valid  out  1  one-cycle pulse; v_out/u_out hold fresh data.
- v_out  out  NUM_WIDTH  v read data.
- u_out  out  NUM_WIDTH  u read data.
- wr_en  in  1  write request.
- wr_tag  in  TAG_BITS  write address.
- v_new  in  NUM_WIDTH  v write data.
- u_new  in  NUM_WIDTH  u write data.

Behaviour:
- Clocking and reset (decided): one clock, clk; reset asyn_reset is asynchronous and active-high.
- Reset values while asyn_reset is high: ready=0, rd_valid=0, v_out=0, u_out=0, FSM=INIT, sweep counter=0. Memory contents are not reset.
- FSM state INIT:
  - Each cycle writes V_INIT/U_INIT to entry[counter], then increments the counter.
  - After entry NUM_NEURONS-1 is written, next state is RUN.
  - The sweep takes exactly NUM_NEURONS cycles after asyn_reset falls; ready rises on the following edge.
- FSM state RUN: ready=1.
  - clr=1 -> INIT with counter=0; ready falls on the next edge.
  - clr in INIT restarts the counter at 0.
- Gating: while ready=0, rd_en and wr_en are ignored. No memory update from the write port, and rd_valid stays 0.
- Write: wr_en && ready at edge t -> entry[wr_tag] = {v_new, u_new}, visible to reads issued at edge t+1 or later.
- Read: rd_en && ready at edge t -> v_out/u_out updated and rd_valid=1 after edge t; rd_valid is 1 for that cycle only. Latency is 1 cycle. Back-to-back reads give a result every cycle.
- Output hold: when rd_valid=0, v_out/u_out hold the last read value and do not return to 0.
- Collision: rd_en and wr_en in the same cycle with rd_tag==wr_tag -> read returns v_new/u_new (write-first bypass). Different tags -> ports are independent.
- clr together with wr_en: clr wins and the write is dropped. clr together with rd_en: the read is dropped and rd_valid=0.
- asyn_reset mid-sweep or mid-read: immediate return to the reset values; the sweep restarts from 0 after release.
- No arithmetic is performed; data passes through bit-exact. Tags are always in range because NUM_NEURONS is a power of two.

Optional Feature:
- Macro: IZH_STATE_PARITY_EN.
- Defined:
  - Each entry stores one even-parity bit over v and one over u.
  - The init sweep and the write port generate the parity bits.
  - A new output par_err (1 bit) is registered alongside rd_valid. It is 1 when either recomputed parity mismatches the stored bit. par_err resets to 0.
  - Bypassed reads (collision case) always report par_err=0.
- Undefined: no parity storage and no par_err port.

Decomposition:
- Package izh_pkg: NUM_WIDTH default, Q8.8 fraction-bit constant (8), V_INIT/U_INIT constants, typedef of the {v,u} state word, FSM state enum {INIT, RUN}.
- One sub-module: izh_state_mem, a simple dual-port array with 1 write and 1 registered read, no reset; parity bits are included when IZH_STATE_PARITY_EN is defined.
- The FSM, gating and bypass logic stay in the top level.

Test Plan:
1. Release asyn_reset with NUM_NEURONS=4 -> ready=0 for 4 cycles, then ready=1. Reading tags 0..3 returns v=-16640, u=-3328 each, with rd_valid one cycle after each rd_en.
2. Write tag2 v=0x00100, u=0x1FF00; next cycle read tag2 -> v_out=0x00100, u_out=0x1FF00. Tags 0, 1 and 3 still hold the init values.
3. Same cycle: wr tag1 v=0x00A00 and rd tag1 -> v_out=0x00A00 (bypass). Same cycle: wr tag1 and rd tag3 -> tag3 returns its old value.
4. In RUN, assert clr together with wr tag0 v=0x00500 -> ready drops for 4 cycles. Tag0 then reads -16640; the write was dropped.
5. Assert asyn_reset at sweep cycle 2 -> outputs go to 0 immediately. After release, ready=1 only after a full 4 more cycles. rd_en pulsed during INIT produces no rd_valid.
6. With IZH_STATE_PARITY_EN defined, force one stored v bit of tag3 to flip, then read tag3 -> par_err=1 in the same cycle as rd_valid. Reading other tags -> par_err=0.
